// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous single-port memory between instruction fetch and load/store.
// Data has priority; a saturating streak counter forces a fetch grant after MAX_DATA_STREAK data wins.
module mem_port_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          err_misalign
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_own_if;
    logic          r_we;
    logic          r_mis;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_streak;
    logic          r_if_rvalid;
    logic          r_d_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_err;

    logic          w_streak_full;
    logic          w_any_req;
    logic          w_pick_if;
    logic [AW-1:0] w_sel_addr;
    logic          w_sel_mis;
    logic          w_active;

    assign w_streak_full = (r_streak == SW'(MAX_DATA_STREAK));
    assign w_any_req     = if_req | d_req;
    assign w_pick_if     = if_req & (~d_req | w_streak_full);
    assign w_sel_addr    = w_pick_if ? if_addr : d_addr;
    assign w_sel_mis     = (w_sel_addr[1:0] != 2'b00);

    always_comb begin
        w_next   = r_state;
        w_active = 1'b0;
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: begin
                w_next   = r_we ? S_IDLE : S_RESP;
                // Gated by clk_en so a stalled ACCESS cycle neither grants nor touches memory.
                w_active = clk_en;
                if_gnt   = w_active & r_own_if;
                d_gnt    = w_active & ~r_own_if;
                mem_en   = w_active & ~r_mis;
                mem_we   = w_active & ~r_mis & r_we;
            end
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_own_if    <= 1'b0;
            r_we        <= 1'b0;
            r_mis       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_streak    <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else if (clk_en) begin
            r_state     <= w_next;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                S_IDLE: if (w_any_req) begin
                    r_own_if <= w_pick_if;
                    r_we     <= w_pick_if ? 1'b0 : d_we;
                    r_addr   <= w_sel_addr;
                    r_wdata  <= w_pick_if ? '0 : d_wdata;
                    r_mis    <= w_sel_mis;
                    r_err    <= r_err | w_sel_mis;
                    // A data win only counts toward the streak while fetch is actually waiting.
                    if (w_pick_if)
                        r_streak <= '0;
                    else if (if_req && !w_streak_full)
                        r_streak <= r_streak + 1'b1;
                end
                S_RESP: begin
                    if (r_own_if) begin
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= r_mis ? '0 : mem_rdata;
                    end else begin
                        r_d_rvalid  <= 1'b1;
                        r_d_rdata   <= r_mis ? '0 : mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_rvalid    = r_if_rvalid;
    assign if_rdata     = r_if_rdata;
    assign d_rvalid     = r_d_rvalid;
    assign d_rdata      = r_d_rdata;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign err_misalign = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic checked
// against a transaction-level model (grant rule, cycle latencies, reference memory).
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          err_misalign;
    logic          mem_clr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err_misalign(err_misalign)
    );

    function automatic logic [DW-1:0] init_word(input int unsigned idx);
        if (idx == 4) return 32'hDEADBEEF;
        return 32'h5A000000 ^ (idx * 32'h00010203);
    endfunction

    // Synchronous single-port memory macro (256 words, word index = addr[9:2]).
    logic [DW-1:0] mem_q       [0:255];
    logic          mem_written [0:255];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_written[i] <= 1'b0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem_q[mem_addr[9:2]]       <= mem_wdata;
                mem_written[mem_addr[9:2]] <= 1'b1;
            end else begin
                mem_rdata <= mem_written[mem_addr[9:2]] ? mem_q[mem_addr[9:2]]
                                                        : init_word(32'(mem_addr[9:2]));
            end
        end
    end

    // Reference memory contents as seen by the model.
    logic [DW-1:0] ref_mem [int unsigned];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        int unsigned i;
        i = 32'(a[9:2]);
        return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = {22'd0, 8'($urandom), 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    string         order;
    string         exp_order;
    int            next_ok;
    int            rv_at;
    bit            rv_if;
    logic [DW-1:0] rv_data;
    logic [DW-1:0] exp_if_rd;
    logic [DW-1:0] exp_d_rd;
    bit            err_m;
    int unsigned   streak_m;
    bit            exp_grant;
    bit            exp_f;
    bit            t_we;
    bit            t_mis;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wd;

    initial begin
        reset = 1'b1; clk_en = 1'b1; mem_clr = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        tick(); tick();
        check("rst_ctrl", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, err_misalign}), 64'd0);
        check("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        check("rst_maddr", 64'({mem_addr, mem_wdata}), 64'd0);
        reset = 1'b0; mem_clr = 1'b0;

        // Fetch-only read of mem[4].
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        check("t2_gnt", 64'({if_gnt, d_gnt, mem_en, mem_we}), 64'(4'b1010));
        check("t2_maddr", 64'(mem_addr), 64'(32'h10));
        if_req = 1'b0;
        tick();
        check("t2_resp", 64'({if_gnt, if_rvalid}), 64'd0);
        tick();
        check("t2_rvalid", 64'({if_rvalid, d_rvalid}), 64'(2'b10));
        check("t2_rdata", 64'(if_rdata), 64'(32'hDEADBEEF));
        tick();
        check("t2_hold", 64'({if_rvalid, if_rdata}), 64'({1'b0, 32'hDEADBEEF}));

        // Reset while in RESP.
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        if_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("t1_async", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, err_misalign}), 64'd0);
        check("t1_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        check("t1_maddr", 64'(mem_addr), 64'd0);
        tick();
        check("t1_norv", 64'({if_rvalid, d_rvalid}), 64'd0);
        reset = 1'b0;
        tick();
        check("t1_idle", 64'({if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en}), 64'd0);

        // Store with a concurrent fetch: data first, fetch two cycles later.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        check("t3_dgnt", 64'({if_gnt, d_gnt, mem_en, mem_we}), 64'(4'b0111));
        check("t3_maddr", 64'({mem_addr, mem_wdata}), 64'({32'h40, 32'h12345678}));
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("t3_gap", 64'({if_gnt, d_gnt, mem_en, mem_we}), 64'd0);
        tick();
        check("t3_ignt", 64'({if_gnt, d_gnt, mem_en, mem_we}), 64'(4'b1010));
        if_req = 1'b0;
        tick(); tick();
        check("t3_irv", 64'({if_rvalid, if_rdata}), 64'({1'b1, 32'hDEADBEEF}));

        // Both ports saturated: streak limit forces every fifth grant to fetch.
        order = "";
        exp_order = "DDDDFDDDDF";
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h10;
        for (int cyc = 0; cyc < 60 && order.len() < 10; cyc++) begin
            tick();
            if (d_gnt)  order = {order, "D"};
            if (if_gnt) order = {order, "F"};
        end
        d_req = 1'b0; if_req = 1'b0;
        check("t4_count", 64'(order.len()), 64'd10);
        for (int i = 0; i < 10; i++)
            check("t4_order", 64'(order[i]), 64'(exp_order[i]));
        tick(); tick();
        check("t4_irv", 64'({if_rvalid, if_rdata}), 64'({1'b1, 32'hDEADBEEF}));
        check("t4_drd", 64'(d_rdata), 64'(32'h12345678));

        // Misaligned load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h22;
        tick();
        check("t5_gnt", 64'({if_gnt, d_gnt, mem_en, mem_we, err_misalign}), 64'(5'b01001));
        d_req = 1'b0;
        tick(); tick();
        check("t5_rv", 64'({d_rvalid, d_rdata}), 64'({1'b1, 32'h0}));
        tick();
        check("t5_sticky", 64'({err_misalign, d_rvalid}), 64'(2'b10));

        // Clock-enable stall while in ACCESS.
        if_req = 1'b1; if_addr = 32'h40;
        @(posedge clk); #1;
        clk_en = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t6_stall", 64'({if_gnt, d_gnt, mem_en, if_rvalid}), 64'd0);
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        #1;
        check("t6_resume", 64'({if_gnt, mem_en, mem_we}), 64'(3'b110));
        check("t6_maddr", 64'(mem_addr), 64'(32'h40));
        if_req = 1'b0;
        tick(); tick();
        check("t6_rv", 64'({if_rvalid, if_rdata}), 64'({1'b1, 32'h12345678}));
        check("t6_err", 64'(err_misalign), 64'd1);

        // Randomized traffic against the transaction model.
        reset = 1'b1; mem_clr = 1'b1;
        tick();
        reset = 1'b0; mem_clr = 1'b0;
        ref_mem.delete();
        next_ok = 1; rv_at = -1; rv_if = 1'b0; rv_data = '0;
        exp_if_rd = '0; exp_d_rd = '0; err_m = 1'b0; streak_m = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            tick();
            exp_grant = (cyc >= next_ok) && (if_req || d_req);
            if (exp_grant) begin
                exp_f = if_req && (!d_req || streak_m == MAXS);
                check("r_gnt", 64'({if_gnt, d_gnt}), 64'({exp_f, !exp_f}));
                t_we   = exp_f ? 1'b0 : d_we;
                t_addr = exp_f ? if_addr : d_addr;
                t_wd   = d_wdata;
                t_mis  = (t_addr[1:0] != 2'b00);
                if (t_mis) err_m = 1'b1;
                check("r_mem_en", 64'({mem_en, mem_we}), 64'({!t_mis, !t_mis && t_we}));
                if (!t_mis) begin
                    check("r_maddr", 64'(mem_addr), 64'(t_addr));
                    if (t_we) begin
                        check("r_mwdata", 64'(mem_wdata), 64'(t_wd));
                        ref_mem[32'(t_addr[9:2])] = t_wd;
                    end
                end
                if (!t_we) begin
                    rv_at   = cyc + 2;
                    rv_if   = exp_f;
                    rv_data = t_mis ? '0 : ref_rd(t_addr);
                end
                if (exp_f) streak_m = 0;
                else if (if_req) streak_m = (streak_m + 1 > MAXS) ? MAXS : streak_m + 1;
                next_ok = cyc + (t_we ? 2 : 3);
                if (exp_f) if_req = 1'b0;
                else d_req = 1'b0;
            end else begin
                check("r_nogrant", 64'({if_gnt, d_gnt, mem_en}), 64'd0);
            end
            check("r_err", 64'(err_misalign), 64'(err_m));
            if (cyc == rv_at) begin
                if (rv_if) exp_if_rd = rv_data;
                else exp_d_rd = rv_data;
            end
            check("r_rvalid", 64'({if_rvalid, d_rvalid}), 64'({cyc == rv_at && rv_if, cyc == rv_at && !rv_if}));
            check("r_rdata", 64'({if_rdata, d_rdata}), 64'({exp_if_rd, exp_d_rd}));

            if (!if_req && $urandom_range(0, 3) != 0) begin
                if_req  = 1'b1;
                if_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = rand_addr();
                d_wdata = $urandom();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
